// File: rtl/btn_bounce_pkg.sv
// Shared types and constants for the bouncy button generator.
package btn_bounce_pkg;

    // Per-channel press sequencer states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BOUNCE_IN  = 2'd1,
        ST_HOLD       = 2'd2,
        ST_BOUNCE_OUT = 2'd3
    } bb_state_t;

    // Galois feedback mask for taps 32,22,2,1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Rotation step between neighbouring channels' views of the LFSR
    localparam int unsigned ROT_STEP = 5;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        logic [63:0] d;
        d = {v, v} << (n % 32);
        return d[63:32];
    endfunction

    // Oscillation count 5, 7, 9 or 11: always odd so the net level flips
    function automatic logic [3:0] osc_count(input logic [1:0] sel);
        return 4'd5 + {1'b0, sel, 1'b0};
    endfunction

endpackage

// File: rtl/lfsr32.sv
// Free-running 32-bit Galois LFSR shared by all button channels.
module lfsr32
    import btn_bounce_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] seed_nz;

    // An all-zero seed would lock the register, so it is replaced by 1
    assign seed_nz = (seed == 32'd0) ? 32'd1 : seed;

    // Advance one step every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= seed_nz;
        else     state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 32'd0);
    end

endmodule

// File: rtl/btn_bounce_gen.sv
// Multi-channel bouncy push-button generator.
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | btn at released level, channel ready for a request
// ST_BOUNCE_IN  | odd number of toggles settling to the pressed level
// ST_HOLD       | btn stable at pressed level for the latched hold count
// ST_BOUNCE_OUT | odd number of toggles settling back to released level
//
// Each toggle starts an oscillation lasting MIN_DLY + random field cycles.
// The last inward toggle lands on HOLD entry, so the pressed level stays
// stable for exactly the hold count; the first outward toggle is HOLD exit.
module btn_bounce_gen
    import btn_bounce_pkg::*;
#(
    parameter int          CHANNELS     = 4,
    parameter logic        ACTIVE_STATE = 1'b1,
    parameter int          DLY_W        = 16,
    parameter int          MIN_DLY      = 1000,
    parameter int          HOLD_W       = 24,
    parameter logic [31:0] SEED         = 32'hACE1_2022,
    localparam int         CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [CH_W-1:0]     req_chan,
    input  logic [HOLD_W-1:0]   req_hold,
    output logic                req_ready,
    output logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] busy
);

    localparam int CNT_W = DLY_W + 1 + $clog2(MIN_DLY);
    localparam int RND_W = DLY_W + 2;

    logic [31:0]            lfsr_state;
    logic [HOLD_W-1:0]      hold_load;
    logic [(1<<CH_W)-1:0]   busy_ext;

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (SEED),
        .state (lfsr_state)
    );

    // A zero hold is treated as one cycle; the counter runs hold-1 down to 0
    assign hold_load = (req_hold == '0) ? '0 : req_hold - HOLD_W'(1);

    // Channel numbers beyond CHANNELS read as busy so they are never ready
    always_comb begin
        busy_ext = '1;
        for (int c = 0; c < CHANNELS; c++) busy_ext[c] = busy[c];
    end

    assign req_ready = ~busy_ext[req_chan];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        bb_state_t         st_q, st_d;
        logic              btn_q, btn_d;
        logic [3:0]        osc_q, osc_d;
        logic [CNT_W-1:0]  dly_q, dly_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [RND_W-1:0]  rnd;
        logic [3:0]        osc_load;
        logic [CNT_W-1:0]  dly_sum;
        logic [CNT_W-1:0]  dly_load;
        logic              acc;

        assign rnd      = RND_W'(rotl32(lfsr_state, ROT_STEP * i));
        assign osc_load = osc_count(rnd[1:0]) - 4'd1;
        assign dly_sum  = CNT_W'(MIN_DLY) + CNT_W'(rnd[DLY_W+1:2]);
        assign dly_load = (dly_sum == '0) ? '0 : dly_sum - CNT_W'(1);
        assign acc      = req_valid & req_ready & (req_chan == CH_W'(i));

        // Next-state, level and counter updates for this channel
        always_comb begin
            st_d   = st_q;
            btn_d  = btn_q;
            osc_d  = osc_q;
            dly_d  = dly_q;
            hold_d = hold_q;
            unique case (st_q)
                ST_IDLE: begin
                    if (acc) begin
                        st_d   = ST_BOUNCE_IN;
                        btn_d  = ~btn_q;
                        osc_d  = osc_load;
                        dly_d  = dly_load;
                        hold_d = hold_load;
                    end
                end
                ST_BOUNCE_IN: begin
                    if (dly_q != '0) begin
                        dly_d = dly_q - CNT_W'(1);
                    end else begin
                        btn_d = ~btn_q;
                        osc_d = osc_q - 4'd1;
                        dly_d = dly_load;
                        if (osc_q == 4'd1) st_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end else begin
                        st_d  = ST_BOUNCE_OUT;
                        btn_d = ~btn_q;
                        osc_d = osc_load;
                        dly_d = dly_load;
                    end
                end
                ST_BOUNCE_OUT: begin
                    if (dly_q != '0) begin
                        dly_d = dly_q - CNT_W'(1);
                    end else if (osc_q != 4'd0) begin
                        btn_d = ~btn_q;
                        osc_d = osc_q - 4'd1;
                        dly_d = dly_load;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        // Channel state register; reset aborts any press in progress
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q   <= ST_IDLE;
                btn_q  <= ~ACTIVE_STATE;
                osc_q  <= '0;
                dly_q  <= '0;
                hold_q <= '0;
            end else begin
                st_q   <= st_d;
                btn_q  <= btn_d;
                osc_q  <= osc_d;
                dly_q  <= dly_d;
                hold_q <= hold_d;
            end
        end

        assign btn[i]  = btn_q;
        assign busy[i] = (st_q != ST_IDLE);
    end

endmodule

// File: doc/btn_bounce_gen.md
BTN_BOUNCE_GEN -- requirements
Module: btn_bounce_gen

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent bouncy button outputs (1..16).
REQ-002 Parameter ACTIVE_STATE, default 1'b1, pressed level of every btn output.
REQ-003 Parameter DLY_W, default 16, width of the random bounce-delay field.
REQ-004 Parameter MIN_DLY, default 1000, minimum cycles per bounce interval.
REQ-005 Parameter HOLD_W, default 24, width of the requested hold duration.
REQ-006 Parameter SEED, default 32'hACE1_2022, LFSR reset value; 0 SHALL be replaced by 1.
REQ-007 clk  input  1  single clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 req_valid  input  1  press request strobe.
REQ-010 req_chan  input  clog2(CHANNELS)  target channel.
REQ-011 req_hold  input  HOLD_W  stable pressed duration in cycles.
REQ-012 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-013 btn  output  CHANNELS  bouncy button levels.
REQ-014 busy  output  CHANNELS  channel i executing a press.

Function
REQ-015 req_ready SHALL equal ~busy[req_chan] combinationally; req_chan >= CHANNELS SHALL give req_ready=0.
REQ-016 Accepted request SHALL set busy[req_chan] on the next cycle and latch req_hold; req_hold=0 SHALL be treated as 1.
REQ-017 Per-channel FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT; IDLE->BOUNCE_IN on accept, BOUNCE_IN->HOLD when oscillations exhausted, HOLD->BOUNCE_OUT when hold counter expires, BOUNCE_OUT->IDLE when oscillations exhausted.
REQ-018 On entry to each BOUNCE state, oscillation count SHALL be 5,7,9 or 11, chosen by 2 LFSR bits (always odd, so net level toggles).
REQ-019 Each oscillation SHALL toggle btn[i] on its first cycle then wait MIN_DLY + lfsr_field[DLY_W-1:0] cycles before the next toggle or state exit.
REQ-020 HOLD SHALL keep btn[i]=ACTIVE_STATE for exactly the latched hold cycles.
REQ-021 After BOUNCE_OUT, btn[i] SHALL equal ~ACTIVE_STATE and busy[i] SHALL clear in the same cycle as entering IDLE.
REQ-022 One 32-bit Galois LFSR (taps 32,22,2,1) SHALL advance every cycle; channel i SHALL draw from the LFSR rotated left by 5*i so simultaneous draws differ.
REQ-023 Delay arithmetic SHALL be done in DLY_W+1+clog2(MIN_DLY) bits with no wrap.
REQ-024 Channels SHALL run fully independently; a request to a busy channel SHALL be ignored and never alter its progress.

Reset
REQ-025 rst SHALL force btn to all ~ACTIVE_STATE, busy to 0, all FSMs to IDLE, counters to 0, LFSR to SEED, regardless of in-progress presses.
REQ-026 After rst deasserts, req_ready SHALL be 1 for every valid channel on the first clock edge.

Structure
REQ-027 FSM state encodings and the LFSR tap constant SHALL live in package btn_bounce_pkg.
REQ-028 The LFSR SHALL be the sub-module lfsr32 (clk, rst, seed, state out); per-channel FSMs SHALL be generate-loop instances of logic in btn_bounce_gen.

Verification
REQ-029 Reset then idle 100 cycles -> btn=4'b0000 (ACTIVE_STATE=1), busy=0, req_ready=1.
REQ-030 Request chan 2, hold 5000, MIN_DLY=10, DLY_W=4 -> odd toggle count in 5..11, each gap 10..25 cycles, btn[2]=1 stable exactly 5000 cycles, then odd toggles, btn[2]=0, busy[2] clears.
REQ-031 Requests chan 0 and chan 3 on consecutive cycles -> both accepted, independent bounce sequences, other channels unchanged at 0.
REQ-032 Second request to chan 1 while busy[1]=1 -> req_ready=0, hold count of original press unchanged.
REQ-033 Assert rst during HOLD on chan 1 -> btn[1]=0 and busy[1]=0 immediately (asynchronously), next request accepted normally.
REQ-034 ACTIVE_STATE=0, req_hold=0 on chan 0 -> idle level 1, pressed level 0 held exactly 1 cycle, final level 1.
